// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scancode constants, frame states and set-2 to ASCII translation
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] ASC_W = 8'h57;
  localparam logic [7:0] ASC_A = 8'h41;
  localparam logic [7:0] ASC_S = 8'h53;
  localparam logic [7:0] ASC_D = 8'h44;
  localparam logic [7:0] ASC_I = 8'h49;
  localparam logic [7:0] ASC_J = 8'h4A;
  localparam logic [7:0] ASC_K = 8'h4B;
  localparam logic [7:0] ASC_L = 8'h4C;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic [7:0] sc_to_ascii(input logic [7:0] sc);
    logic [7:0] asc;
    case (sc)
      8'h1C: asc = 8'h41;  8'h32: asc = 8'h42;  8'h21: asc = 8'h43;
      8'h23: asc = 8'h44;  8'h24: asc = 8'h45;  8'h2B: asc = 8'h46;
      8'h34: asc = 8'h47;  8'h33: asc = 8'h48;  8'h43: asc = 8'h49;
      8'h3B: asc = 8'h4A;  8'h42: asc = 8'h4B;  8'h4B: asc = 8'h4C;
      8'h3A: asc = 8'h4D;  8'h31: asc = 8'h4E;  8'h44: asc = 8'h4F;
      8'h4D: asc = 8'h50;  8'h15: asc = 8'h51;  8'h2D: asc = 8'h52;
      8'h1B: asc = 8'h53;  8'h2C: asc = 8'h54;  8'h3C: asc = 8'h55;
      8'h2A: asc = 8'h56;  8'h1D: asc = 8'h57;  8'h22: asc = 8'h58;
      8'h35: asc = 8'h59;  8'h1A: asc = 8'h5A;
      8'h29: asc = 8'h20;
      8'h5A: asc = 8'h0D;
      default: asc = 8'h00;
    endcase
    return asc;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and 11-bit frame receiver with timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       err_stb
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // The filtered level only flips after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_MAX) begin
      clk_filt <= clk_sync[1];
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + 1'b1;
    end
  end

  assign fall = clk_filt && !clk_sync[1] && (flt_cnt == FLT_MAX);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!dat_sync[1]) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end else begin
              err_stb <= 1'b1;
            end
          end
          RX_DATA: begin
            shreg   <= {dat_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= dat_sync[1];
            state   <= RX_STOP;
          end
          RX_STOP: begin
            if (dat_sync[1] && (^{shreg, par_bit})) begin
              rx_byte  <= shreg;
              byte_stb <= 1'b1;
            end else begin
              err_stb <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (to_cnt == TO_MAX) begin
          state   <= RX_IDLE;
          err_stb <= 1'b1;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 keyboard front end presenting the held key as ASCII
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       FRAME_ERR
);

  logic [7:0] rx_byte;
  logic       byte_stb;
  logic       err_stb;
  logic       brk_flag;
  logic       ext_flag;
  logic       is_prefix;
  logic [7:0] asc;
  logic [7:0] key_next;

  ps2_frame_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .rx_byte (rx_byte),
    .byte_stb(byte_stb),
    .err_stb (err_stb)
  );

  assign is_prefix = (rx_byte == SC_BREAK) || (rx_byte == SC_EXT);
  assign asc       = sc_to_ascii(rx_byte);

  // A release only clears the key it names, so letting go of an older key keeps the newer one.
  always_comb begin
    key_next = KEY_CODE;
    if (byte_stb && !is_prefix && !ext_flag) begin
      if (brk_flag) begin
        if (asc == KEY_CODE) key_next = 8'h00;
      end else if (asc != 8'h00) begin
        key_next = asc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      KEY_CODE  <= 8'h00;
      KEY_VALID <= 1'b0;
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
    end else begin
      KEY_VALID <= (key_next != KEY_CODE);
      KEY_CODE  <= key_next;
      if (byte_stb) begin
        if (rx_byte == SC_BREAK) begin
          brk_flag <= 1'b1;
        end else if (rx_byte == SC_EXT) begin
          ext_flag <= 1'b1;
        end else begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end
    end
  end

  assign FRAME_ERR = err_stb;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  localparam int TO_CYC = 2000;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic [7:0] KEY_CODE;
  logic       KEY_VALID;
  logic       FRAME_ERR;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int kv_cnt = 0;
  int fe_cnt = 0;
  int last_kv_cyc = -1;
  int stop_fall_cyc = 0;

  logic [7:0] exp_key = 8'h00;
  bit         exp_brk = 0;
  bit         exp_ext = 0;
  int         exp_kv = 0;
  int         exp_fe = 0;

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK(CLK), .RSTn(RSTn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .KEY_CODE(KEY_CODE), .KEY_VALID(KEY_VALID), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RSTn) begin
      if (KEY_VALID) begin
        kv_cnt++;
        last_kv_cyc = cyc;
      end
      if (FRAME_ERR) fe_cnt++;
    end
  end

  function automatic logic [7:0] model_ascii(input logic [7:0] sc);
    string      letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    logic [7:0] codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    if (sc == 8'h29) return 8'h20;
    if (sc == 8'h5A) return 8'h0D;
    for (int i = 0; i < 26; i++)
      if (codes[i] == sc) return letters[i];
    return 8'h00;
  endfunction

  task automatic model_byte(input logic [7:0] sc, input bit bad);
    logic [7:0] a;
    logic [7:0] old;
    if (bad) begin
      exp_fe++;
      return;
    end
    if (sc == 8'hF0) begin exp_brk = 1; return; end
    if (sc == 8'hE0) begin exp_ext = 1; return; end
    old = exp_key;
    a = model_ascii(sc);
    if (!exp_ext) begin
      if (exp_brk) begin
        if (a == exp_key) exp_key = 8'h00;
      end else if (a != 8'h00) begin
        exp_key = a;
      end
    end
    exp_brk = 0;
    exp_ext = 0;
    if (exp_key != old) exp_kv++;
  endtask

  // Drives the first nbits of start, 8 data LSB-first, parity, stop.
  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits, input int half);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      PS2_DAT = fr[i];
      repeat (half) @(negedge CLK);
      PS2_CLK = 1'b0;
      if (i == 10) stop_fall_cyc = cyc;
      repeat (half) @(negedge CLK);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
    repeat (30) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(b, bad_par, bad_stop, 11, $urandom_range(12, 24));
    model_byte(b, bad_par | bad_stop);
  endtask

  task automatic check_state(input string name);
    n_tests++;
    if (KEY_CODE !== exp_key || kv_cnt != exp_kv || fe_cnt != exp_fe) begin
      n_fail++;
      $display("FAIL %s: KEY_CODE=%h kv=%0d fe=%0d, expected KEY_CODE=%h kv=%0d fe=%0d",
               name, KEY_CODE, kv_cnt, fe_cnt, exp_key, exp_kv, exp_fe);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (KEY_CODE !== 8'h00 || KEY_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: KEY_CODE=%h KEY_VALID=%b FRAME_ERR=%b, expected 00 0 0",
               KEY_CODE, KEY_VALID, FRAME_ERR);
    end
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_make_latency();
    send_frame(8'h1D, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h57) begin
      n_fail++;
      $display("FAIL make_w: KEY_CODE=%h expected 57", KEY_CODE);
    end
    n_tests++;
    if (last_kv_cyc - stop_fall_cyc != 11) begin
      n_fail++;
      $display("FAIL latency: KEY_VALID %0d cycles after stop edge, expected 11",
               last_kv_cyc - stop_fall_cyc);
    end
    check_state("make_w_counts");
  endtask

  task automatic test_release();
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1D, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h00 || kv_cnt != 2) begin
      n_fail++;
      $display("FAIL release_w: KEY_CODE=%h kv=%0d expected 00 kv=2", KEY_CODE, kv_cnt);
    end
  endtask

  task automatic test_overlap();
    send_frame(8'h1C, 0, 0);
    send_frame(8'h23, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h44) begin
      n_fail++;
      $display("FAIL overlap_a_release: KEY_CODE=%h expected 44", KEY_CODE);
    end
    send_frame(8'hF0, 0, 0);
    send_frame(8'h23, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h00) begin
      n_fail++;
      $display("FAIL overlap_d_release: KEY_CODE=%h expected 00", KEY_CODE);
    end
    check_state("overlap_counts");
  endtask

  task automatic test_frame_err();
    send_frame(8'h1D, 1, 0);
    n_tests++;
    if (KEY_CODE !== 8'h00 || fe_cnt != exp_fe) begin
      n_fail++;
      $display("FAIL parity_err: KEY_CODE=%h fe=%0d expected 00 fe=%0d", KEY_CODE, fe_cnt, exp_fe);
    end
    send_frame(8'h3B, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h4A) begin
      n_fail++;
      $display("FAIL after_parity_err: KEY_CODE=%h expected 4A", KEY_CODE);
    end
    send_frame(8'h1D, 0, 1);
    check_state("bad_stop");
  endtask

  task automatic test_ext_glitch();
    int kv0;
    kv0 = kv_cnt;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h75, 0, 0);
    n_tests++;
    if (kv_cnt != kv0) begin
      n_fail++;
      $display("FAIL ext_no_valid: kv=%0d expected %0d", kv_cnt, kv0);
    end
    @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (3) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (30) @(negedge CLK);
    check_state("glitch_ignored");
    send_frame(8'h42, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h4B) begin
      n_fail++;
      $display("FAIL after_ext: KEY_CODE=%h expected 4B", KEY_CODE);
    end
  endtask

  task automatic test_timeout();
    send_bits(8'h4B, 0, 0, 5, 15);
    repeat (TO_CYC + 200) @(negedge CLK);
    exp_fe++;
    check_state("timeout");
    send_frame(8'h4B, 0, 0);
    n_tests++;
    if (KEY_CODE !== 8'h4C) begin
      n_fail++;
      $display("FAIL after_timeout: KEY_CODE=%h expected 4C", KEY_CODE);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(8'h1B, 0, 0, 4, 15);
    @(negedge CLK);
    RSTn = 1'b0;
    #1;
    n_tests++;
    if (KEY_CODE !== 8'h00 || KEY_VALID !== 1'b0 || FRAME_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: KEY_CODE=%h KEY_VALID=%b FRAME_ERR=%b expected 00 0 0",
               KEY_CODE, KEY_VALID, FRAME_ERR);
    end
    exp_key = 8'h00;
    exp_brk = 0;
    exp_ext = 0;
    repeat (3) @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h1B, 0, 0);
    check_state("after_reset_midframe");
  endtask

  task automatic test_random();
    logic [7:0] keys [10] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h29, 8'h5A};
    logic [7:0] junk [3]  = '{8'h76, 8'h05, 8'h66};
    logic [7:0] b;
    int r;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hF0;
      else if (r == 1) b = 8'hE0;
      else if (r == 2) b = junk[$urandom_range(0, 2)];
      else             b = keys[$urandom_range(0, 9)];
      send_frame(b, ($urandom_range(0, 7) == 0), 1'b0);
      check_state($sformatf("random_%0d_%h", n, b));
    end
  endtask

  initial begin
    test_reset();
    test_make_latency();
    test_release();
    test_overlap();
    test_frame_err();
    test_ext_glitch();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream keyboard front end. Receives PS/2 set-2 scancode frames on PS2_CLK/PS2_DAT, validates each frame, handles the F0 break and E0 extended prefixes, and translates make codes to uppercase ASCII. It presents a level "currently held key" byte on KEY_CODE. The downstream direction decoder compares that byte against 'W','A','S','D','I','J','K','L' every cycle.

Parameters:
FILTER_LEN, 8, consecutive CLK samples for which synchronized PS2_CLK must be stable before an edge is accepted (glitch filter)
TIMEOUT_CYC, 100000, CLK cycles without an accepted PS2_CLK falling edge mid-frame before the frame is aborted

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
PS2_CLK  in  1  raw keyboard clock, asynchronous, idle high
PS2_DAT  in  1  raw keyboard data, asynchronous, idle high
KEY_CODE  out  8  ASCII of the last pressed key still held; 8'h00 when no mapped key is held
KEY_VALID  out  1  one-cycle pulse when KEY_CODE changes value
FRAME_ERR  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset is RSTn, asynchronous, active-low; clock is CLK. In reset: KEY_CODE=8'h00, KEY_VALID=0, FRAME_ERR=0, break/ext flags cleared, frame FSM in IDLE, all counters zero.
- Input conditioning: PS2_CLK and PS2_DAT each pass through a 2-FF synchronizer. Filtered clock level changes only after FILTER_LEN identical consecutive synced samples. A falling edge of the filtered clock is the bit strobe; PS2_DAT (synced) is sampled on that cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with DAT=0 -> DATA, bit count=0. Strobe with DAT=1 -> FRAME_ERR, stay in IDLE.
  - DATA: shift the bit in LSB-first. After the 8th bit -> PARITY.
  - PARITY: record the bit -> STOP.
  - STOP: if DAT=1 and the XOR of 8 data bits plus parity equals 1 (odd parity), emit a byte strobe with the byte. Otherwise FRAME_ERR. Return to IDLE either way.
- Timeout: a counter resets on every strobe and counts in all non-IDLE states. On reaching TIMEOUT_CYC the FSM goes to IDLE and FRAME_ERR pulses. Any partial byte is discarded; KEY_CODE is unaffected.
- Byte strobe latency: the byte strobe occurs 1 CLK after the stop-bit strobe. KEY_CODE and KEY_VALID update 1 CLK after the byte strobe.
- Prefix handling on the byte strobe:
  - 8'hF0 sets the break flag.
  - 8'hE0 sets the ext flag.
  - Any other byte is a key byte. It is processed, then both flags are cleared.
- Key byte processing:
  - ext=1: ignored. No mapping; KEY_CODE unchanged.
  - Translation table: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A. Also space 29 -> 8'h20 and enter 5A -> 8'h0D. All other codes map to 8'h00.
  - Make (break=0) with a nonzero mapping: KEY_CODE <= ASCII.
  - Break (break=1): if the mapping equals the current KEY_CODE, KEY_CODE <= 8'h00. Otherwise KEY_CODE is unchanged, so releasing an older key does not clear a newer one.
  - Unmapped make: no change.
- KEY_VALID pulses only when the new KEY_CODE differs from the old one. Typematic repeats of the held key therefore produce no pulse.
- FRAME_ERR and a byte strobe never occur in the same cycle. A bad frame never alters the flags or KEY_CODE.
- RSTn asserted mid-frame: immediate return to reset values. After release the FSM waits in IDLE for a clean start bit.

Decomposition:
- Shared package ps2_pkg holds:
  - Constants SC_BREAK=8'hF0 and SC_EXT=8'hE0.
  - The ASCII constants for W,A,S,D,I,J,K,L used by the downstream decoder.
  - The scancode-to-ASCII translation function.
- Sub-module ps2_frame_rx: synchronizer, glitch filter, frame FSM and timeout. Outputs byte[7:0], byte_stb and err_stb.
- The top level holds the prefix flags, translation and KEY_CODE register.

Test Plan:
- Frame 1D (W make, parity 1) -> KEY_CODE=8'h57; KEY_VALID pulses once, 2 CLK after the stop-bit strobe.
- Sequence 1D, then F0 1D -> KEY_CODE 8'h57 then 8'h00; two KEY_VALID pulses.
- Sequence 1C (A), 23 (D), then F0 1C -> KEY_CODE ends at 8'h44, unchanged by the A release; F0 23 then gives 8'h00.
- Frame 1D with the parity bit inverted -> FRAME_ERR pulses once; KEY_CODE stays 8'h00. A following good 3B gives 8'h4A.
- Sequence E0 75 (ext up arrow) -> no KEY_VALID; the next plain 42 gives 8'h4B. Also inject a 3-cycle PS2_CLK low glitch -> no bit accepted.
- Stop the clock after 4 data bits for TIMEOUT_CYC cycles -> FRAME_ERR pulses; a subsequent full 4B frame gives 8'h4C. Asserting RSTn mid-frame gives all outputs 0.
